// File: rtl/bcp_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : bcp_engine_if                                        |
// | Description : Memory-side bundle of bcp_engine: clause memory      |
// |               read port, variable-state read port and imply-stack  |
// |               push port. master = engine, slave = memories/stack.  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

interface bcp_engine_if #(
  parameter int LITS_PER_CLAUSE = 3
);
  localparam int c_cb = `MAX_CLAUSES_BITS;
  localparam int c_vb = `MAX_VARS_BITS;

  logic                              clause_rd;
  logic [c_cb-1:0]                   clause_addr;
  logic [LITS_PER_CLAUSE*c_vb-1:0]   clause_lit_var;
  logic [LITS_PER_CLAUSE-1:0]        clause_lit_neg;
  logic [LITS_PER_CLAUSE-1:0]        clause_lit_valid;
  logic                              vs_rd;
  logic [c_vb-1:0]                   vs_rd_var;
  logic                              vs_val;
  logic                              vs_unassigned;
  logic                              push_imply;
  logic [c_vb-1:0]                   var_in_imply;
  logic                              val_in_imply;
  logic                              full_imply;

  modport master (
    output clause_rd, clause_addr,
    input  clause_lit_var, clause_lit_neg, clause_lit_valid,
    output vs_rd, vs_rd_var,
    input  vs_val, vs_unassigned,
    output push_imply, var_in_imply, val_in_imply,
    input  full_imply
  );

  modport slave (
    input  clause_rd, clause_addr,
    output clause_lit_var, clause_lit_neg, clause_lit_valid,
    input  vs_rd, vs_rd_var,
    output vs_val, vs_unassigned,
    input  push_imply, var_in_imply, val_in_imply,
    output full_imply
  );
endinterface

`default_nettype wire

// File: rtl/bcp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : bcp_engine                                           |
// | Description : Boolean constraint propagation over a clause range.  |
// |               Pushes implications of unit clauses, reports the     |
// |               first falsified clause as a conflict.                |
// |               Optional macro BCP_STATS_EN adds visit/push counters.|
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module bcp_engine #(
  parameter int LITS_PER_CLAUSE = 3,
  parameter int LIT_IDX_BITS    = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          reset_bcp,
  input  logic [`MAX_CLAUSES_BITS-1:0]  start_clause,
  input  logic [`MAX_CLAUSES_BITS-1:0]  end_clause,
  output logic                          bcp_busy,
  output logic                          conflict,
  output logic                          overflow,
  output logic [`MAX_CLAUSES_BITS-1:0]  bcp_clause_idx,
  bcp_engine_if.master                  bus
`ifdef BCP_STATS_EN
  ,
  output logic [15:0]                   stat_clauses,
  output logic [15:0]                   stat_implies
`endif
);
  localparam int c_cb = `MAX_CLAUSES_BITS;
  localparam int c_vb = `MAX_VARS_BITS;

  localparam logic [3:0] c_idle     = 4'd0;
  localparam logic [3:0] c_fetch    = 4'd1;
  localparam logic [3:0] c_latch    = 4'd2;
  localparam logic [3:0] c_lit_req  = 4'd3;
  localparam logic [3:0] c_lit_eval = 4'd4;
  localparam logic [3:0] c_classify = 4'd5;
  localparam logic [3:0] c_push     = 4'd6;
  localparam logic [3:0] c_next     = 4'd7;
  localparam logic [3:0] c_conflict = 4'd8;
  localparam logic [3:0] c_done     = 4'd9;

  logic [3:0]                 r_state;
  logic [c_cb-1:0]            r_idx;
  logic [c_cb-1:0]            r_end;
  logic [c_cb-1:0]            r_clause_idx;
  logic                       r_busy;
  logic                       r_conflict;
  logic                       r_overflow;
  logic [c_vb-1:0]            r_var [LITS_PER_CLAUSE];
  logic [LITS_PER_CLAUSE-1:0] r_neg;
  logic [LITS_PER_CLAUSE-1:0] r_valid;
  logic [LIT_IDX_BITS-1:0]    r_lit;
  logic [1:0]                 r_ucnt;
  logic [c_vb-1:0]            r_unit_var;
  logic                       r_unit_val;

  // Lowest valid slot at or above 'from'; MSB of the result flags "found".
  function automatic logic [LIT_IDX_BITS:0] find_valid(
    input logic [LITS_PER_CLAUSE-1:0] valid,
    input logic [LIT_IDX_BITS-1:0]    from
  );
    logic [LIT_IDX_BITS:0] res;
    res = '0;
    for (int i = LITS_PER_CLAUSE - 1; i >= 0; i--) begin
      if (valid[i] && (i >= int'(from))) res = {1'b1, LIT_IDX_BITS'(i)};
    end
    return res;
  endfunction

  logic [LIT_IDX_BITS:0] w_first;
  logic [LIT_IDX_BITS:0] w_req;
  logic [LIT_IDX_BITS:0] w_after;
  logic [c_cb-1:0]       w_idx_inc;
  logic                  w_lit_true;

  // Slot look-ups: first slot of a fresh clause, slot to query now, and
  // whether any slot remains after the one being evaluated (saves a cycle).
  always_comb begin
    w_first    = find_valid(bus.clause_lit_valid, '0);
    w_req      = find_valid(r_valid, r_lit);
    w_after    = find_valid(r_valid, r_lit + LIT_IDX_BITS'(1));
    w_idx_inc  = r_idx + c_cb'(1);
    w_lit_true = !bus.vs_unassigned && (bus.vs_val != r_neg[r_lit]);
  end

  assign bus.clause_rd    = (r_state == c_fetch);
  assign bus.clause_addr  = r_idx;
  assign bus.vs_rd        = (r_state == c_lit_req) && w_req[LIT_IDX_BITS];
  assign bus.vs_rd_var    = r_var[w_req[LIT_IDX_BITS-1:0]];
  assign bus.push_imply   = (r_state == c_push) && !bus.full_imply;
  assign bus.var_in_imply = r_unit_var;
  assign bus.val_in_imply = r_unit_val;
  assign bcp_busy         = r_busy;
  assign conflict         = r_conflict;
  assign overflow         = r_overflow;
  assign bcp_clause_idx   = r_clause_idx;

  // Main propagation state machine and its datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_idle;
      r_idx        <= '0;
      r_end        <= '0;
      r_clause_idx <= '0;
      r_busy       <= 1'b0;
      r_conflict   <= 1'b0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < LITS_PER_CLAUSE; i++) r_var[i] <= '0;
      r_neg        <= '0;
      r_valid      <= '0;
      r_lit        <= '0;
      r_ucnt       <= '0;
      r_unit_var   <= '0;
      r_unit_val   <= 1'b0;
    end else if (reset_bcp) begin
      r_state      <= c_idle;
      r_busy       <= 1'b0;
      r_conflict   <= 1'b0;
      r_overflow   <= 1'b0;
      r_clause_idx <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_idx        <= start_clause;
            r_end        <= end_clause;
            r_clause_idx <= start_clause;
            r_conflict   <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= (start_clause >= end_clause) ? c_done : c_fetch;
          end
        end
        c_fetch: begin
          r_clause_idx <= r_idx;
          r_state      <= c_latch;
        end
        c_latch: begin
          for (int i = 0; i < LITS_PER_CLAUSE; i++)
            r_var[i] <= bus.clause_lit_var[i*c_vb +: c_vb];
          r_neg   <= bus.clause_lit_neg;
          r_valid <= bus.clause_lit_valid;
          r_lit   <= '0;
          r_ucnt  <= '0;
          // An all-invalid clause is empty and goes straight to a conflict.
          r_state <= w_first[LIT_IDX_BITS] ? c_lit_req : c_classify;
        end
        c_lit_req: begin
          if (w_req[LIT_IDX_BITS]) begin
            r_lit   <= w_req[LIT_IDX_BITS-1:0];
            r_state <= c_lit_eval;
          end else begin
            r_state <= c_classify;
          end
        end
        c_lit_eval: begin
          if (w_lit_true) begin
            r_state <= c_next;
          end else begin
            if (bus.vs_unassigned) begin
              if (r_ucnt != 2'd2) r_ucnt <= r_ucnt + 2'd1;
              r_unit_var <= r_var[r_lit];
              r_unit_val <= !r_neg[r_lit];
            end
            r_lit   <= r_lit + LIT_IDX_BITS'(1);
            r_state <= w_after[LIT_IDX_BITS] ? c_lit_req : c_classify;
          end
        end
        c_classify: begin
          case (r_ucnt)
            2'd0: begin
              r_conflict <= 1'b1;
              r_state    <= c_conflict;
            end
            2'd1:    r_state <= c_push;
            default: r_state <= c_next;
          endcase
        end
        c_push: begin
          if (bus.full_imply) r_overflow <= 1'b1;
          r_state <= c_next;
        end
        c_next: begin
          r_idx <= w_idx_inc;
          if (w_idx_inc == r_end) begin
            r_busy  <= 1'b0;
            r_state <= c_done;
          end else begin
            r_state <= c_fetch;
          end
        end
        c_conflict: begin
          r_busy  <= 1'b0;
          r_state <= c_done;
        end
        c_done: begin
          r_busy  <= 1'b0;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef BCP_STATS_EN
  logic [15:0] r_stat_clauses;
  logic [15:0] r_stat_implies;

  assign stat_clauses = r_stat_clauses;
  assign stat_implies = r_stat_implies;

  // Saturating counters of finished clauses and successful pushes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_clauses <= '0;
      r_stat_implies <= '0;
    end else if (reset_bcp || (r_state == c_idle && start)) begin
      r_stat_clauses <= '0;
      r_stat_implies <= '0;
    end else begin
      if ((r_state == c_next || r_state == c_conflict) && r_stat_clauses != 16'hFFFF)
        r_stat_clauses <= r_stat_clauses + 16'd1;
      if (bus.push_imply && r_stat_implies != 16'hFFFF)
        r_stat_implies <= r_stat_implies + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_bcp_engine                                        |
// | Description : Self-checking bench for bcp_engine with clause and   |
// |               variable-state memory models and a clause-level      |
// |               reference model of propagation results and timing.   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module tb_bcp_engine;
  localparam int CB = `MAX_CLAUSES_BITS;
  localparam int VB = `MAX_VARS_BITS;
  localparam int L  = 3;
  localparam int NC = 1 << CB;
  localparam int NV = 1 << VB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          reset_bcp = 1'b0;
  logic [CB-1:0] start_clause = '0;
  logic [CB-1:0] end_clause = '0;
  logic          bcp_busy, conflict, overflow;
  logic [CB-1:0] bcp_clause_idx;
`ifdef BCP_STATS_EN
  logic [15:0]   stat_clauses, stat_implies;
`endif

  bcp_engine_if #(.LITS_PER_CLAUSE(L)) bus ();

  bcp_engine #(.LITS_PER_CLAUSE(L), .LIT_IDX_BITS(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .reset_bcp      (reset_bcp),
    .start_clause   (start_clause),
    .end_clause     (end_clause),
    .bcp_busy       (bcp_busy),
    .conflict       (conflict),
    .overflow       (overflow),
    .bcp_clause_idx (bcp_clause_idx),
    .bus            (bus.master)
`ifdef BCP_STATS_EN
    ,
    .stat_clauses   (stat_clauses),
    .stat_implies   (stat_implies)
`endif
  );

  always #5 clock = ~clock;

  // Memory images
  logic [VB-1:0] m_var [NC][L];
  bit            m_neg [NC][L];
  bit            m_vld [NC][L];
  bit            s_val [NV];
  bit            s_un  [NV];

  // Observations
  int rd_q[$];
  int push_q[$];
  int vs_cnt = 0;

  // Reference-model results
  int exp_reads[$];
  int exp_push[$];
  int exp_conf, exp_idx, exp_ovf, exp_cyc, exp_vs;
  int last_cyc;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [L*VB-1:0] t_var;
  logic [L-1:0]    t_neg, t_vld;

  // Clause memory: one-cycle read latency.
  always @(posedge clock) begin
    if (bus.clause_rd) begin
      rd_q.push_back(int'(bus.clause_addr));
      for (int i = 0; i < L; i++) begin
        t_var[i*VB +: VB] = m_var[bus.clause_addr][i];
        t_neg[i]          = m_neg[bus.clause_addr][i];
        t_vld[i]          = m_vld[bus.clause_addr][i];
      end
      bus.clause_lit_var   <= t_var;
      bus.clause_lit_neg   <= t_neg;
      bus.clause_lit_valid <= t_vld;
    end
  end

  // Variable-state memory: one-cycle read latency.
  always @(posedge clock) begin
    if (bus.vs_rd) begin
      vs_cnt++;
      bus.vs_val        <= s_val[bus.vs_rd_var];
      bus.vs_unassigned <= s_un[bus.vs_rd_var];
    end
  end

  // Imply stack: record every push.
  always @(posedge clock) begin
    if (bus.push_imply) push_q.push_back(int'({bus.var_in_imply, bus.val_in_imply}));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < L; i++) begin
        m_var[c][i] = '0; m_neg[c][i] = 0; m_vld[c][i] = 0;
      end
    for (int v = 0; v < NV; v++) begin
      s_val[v] = 0; s_un[v] = 1;
    end
  endtask

  task automatic set_clause(input int c, input int v0, n0, ok0, v1, n1, ok1, v2, n2, ok2);
    m_var[c][0] = VB'(v0); m_neg[c][0] = n0[0]; m_vld[c][0] = ok0[0];
    m_var[c][1] = VB'(v1); m_neg[c][1] = n1[0]; m_vld[c][1] = ok1[0];
    m_var[c][2] = VB'(v2); m_neg[c][2] = n2[0]; m_vld[c][2] = ok2[0];
  endtask

  // Clause-level model: evaluate each clause of [s,e) in order from the
  // memory images, stopping at the first falsified one.
  task automatic model(input int s, input int e, input bit full);
    int k, nun, uv, uval;
    bit sat, lv, is_true;
    exp_reads.delete(); exp_push.delete();
    exp_conf = 0; exp_idx = 0; exp_ovf = 0; exp_vs = 0;
    if (s >= e) begin
      exp_cyc = 1;
      return;
    end
    exp_cyc = 0;
    for (int c = s; c < e; c++) begin
      k = 0; nun = 0; sat = 0; uv = 0; uval = 0;
      exp_reads.push_back(c);
      for (int i = 0; i < L; i++) begin
        if (!sat && m_vld[c][i]) begin
          k++;
          if (s_un[m_var[c][i]]) begin
            nun++;
            uv   = int'(m_var[c][i]);
            uval = m_neg[c][i] ? 0 : 1;
          end else begin
            lv      = s_val[m_var[c][i]];
            is_true = (lv != m_neg[c][i]);
            if (is_true) sat = 1;
          end
        end
      end
      exp_vs  += k;
      exp_cyc += 2 + 2 * k + 1;          // fetch, latch, literals, next
      if (sat) continue;
      exp_cyc += 1;                      // classify
      if (nun == 0) begin
        exp_conf = 1;
        exp_idx  = c;
        break;
      end
      if (nun == 1) begin
        exp_cyc += 1;                    // push
        if (full) exp_ovf = 1;
        else exp_push.push_back(uv * 2 + uval);
      end
    end
  endtask

  task automatic run(input int s, input int e, input bit full, input string tag);
    int r0, p0, v0, cyc;
    model(s, e, full);
    r0 = rd_q.size(); p0 = push_q.size(); v0 = vs_cnt; cyc = 0;
    @(negedge clock);
    start_clause = CB'(s); end_clause = CB'(e); bus.full_imply = full; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_conf_cleared"}, int'(conflict), 0);
    check({tag, "_ovf_cleared"}, int'(overflow), 0);
    while (bcp_busy && cyc <= 400) begin
      cyc++;
      @(negedge clock);
    end
    last_cyc = cyc;
    check({tag, "_busy_cycles"}, cyc, exp_cyc);
    check({tag, "_conflict"}, int'(conflict), exp_conf);
    check({tag, "_overflow"}, int'(overflow), exp_ovf);
    if (exp_conf != 0) check({tag, "_conf_idx"}, int'(bcp_clause_idx), exp_idx);
    check({tag, "_vs_reads"}, vs_cnt - v0, exp_vs);
    check({tag, "_n_reads"}, rd_q.size() - r0, exp_reads.size());
    for (int i = 0; i < exp_reads.size() && r0 + i < rd_q.size(); i++)
      check({tag, "_read_addr"}, rd_q[r0 + i], exp_reads[i]);
    check({tag, "_n_push"}, push_q.size() - p0, exp_push.size());
    for (int i = 0; i < exp_push.size() && p0 + i < push_q.size(); i++)
      check({tag, "_push"}, push_q[p0 + i], exp_push[i]);
  endtask

  initial begin
    int r0, p0, guard, s, e;
    bit saw5;
    bus.clause_lit_var = '0; bus.clause_lit_neg = '0; bus.clause_lit_valid = '0;
    bus.vs_val = 1'b0; bus.vs_unassigned = 1'b0; bus.full_imply = 1'b0;
    clear_mem();

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", int'(bcp_busy), 0);
    check("rst_conflict", int'(conflict), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_idx", int'(bcp_clause_idx), 0);
    check("rst_outs", int'({bus.clause_rd, bus.vs_rd, bus.push_imply, bus.val_in_imply}), 0);
    check("rst_buses", int'({bus.clause_addr, bus.vs_rd_var, bus.var_in_imply}), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Unit clause (x1, !x2, x3): implies x3=1 after 11 busy cycles
    set_clause(0, 1, 0, 1, 2, 1, 1, 3, 0, 1);
    s_val[1] = 0; s_un[1] = 0; s_val[2] = 1; s_un[2] = 0;
    p0 = push_q.size();
    run(0, 1, 0, "unit");
    check("unit_cycles_11", last_cyc, 11);
    check("unit_one_push", push_q.size() - p0, 1);
    if (push_q.size() > p0) check("unit_push_val", push_q[p0], 3 * 2 + 1);

    // Conflict at clause 4; clause 5 must never be read
    clear_mem();
    set_clause(4, 1, 0, 1, 2, 0, 1, 0, 0, 0);
    set_clause(5, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    s_val[1] = 0; s_un[1] = 0; s_val[2] = 0; s_un[2] = 0;
    r0 = rd_q.size();
    run(4, 6, 0, "confl");
    check("confl_idx4", int'(bcp_clause_idx), 4);
    saw5 = 0;
    for (int i = r0; i < rd_q.size(); i++) if (rd_q[i] == 5) saw5 = 1;
    check("confl_no_read5", int'(saw5), 0);

    // Early satisfied: x5=1 stops after one variable read
    clear_mem();
    set_clause(0, 5, 0, 1, 6, 0, 1, 7, 0, 1);
    s_val[5] = 1; s_un[5] = 0;
    r0 = vs_cnt;
    run(0, 1, 0, "early");
    check("early_one_vs_rd", vs_cnt - r0, 1);

    // Empty range
    run(7, 7, 0, "empty");
    check("empty_busy_1", last_cyc, 1);

    // Full stack: overflow instead of push, next start clears it
    clear_mem();
    set_clause(0, 1, 0, 1, 2, 1, 1, 3, 0, 1);
    s_val[1] = 0; s_un[1] = 0; s_val[2] = 1; s_un[2] = 0;
    run(0, 1, 1, "full");
    check("full_overflow", int'(overflow), 1);
    run(0, 1, 0, "after_full");

    // Abort during literal evaluation of a long range
    clear_mem();
    for (int c = 0; c < 10; c++) set_clause(c, 8, 0, 1, 9, 1, 1, 10, 0, 1);
    @(negedge clock);
    start_clause = CB'(0); end_clause = CB'(10); bus.full_imply = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!bus.vs_rd && guard < 50) begin
      guard++;
      @(negedge clock);
    end
    check("abort_saw_vs_rd", int'(bus.vs_rd), 1);
    @(negedge clock);
    reset_bcp = 1'b1;
    @(negedge clock);
    reset_bcp = 1'b0;
    check("abort_busy", int'(bcp_busy), 0);
    check("abort_conflict", int'(conflict), 0);
    check("abort_idx", int'(bcp_clause_idx), 0);
    r0 = rd_q.size();
    repeat (6) @(negedge clock);
    check("abort_no_reads", rd_q.size() - r0, 0);
    check("abort_idle_busy", int'(bcp_busy), 0);
    run(2, 3, 0, "post_abort");

    // Randomized ranges and memory contents
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < L; i++) begin
          m_var[c][i] = VB'($urandom_range(0, NV - 1));
          m_neg[c][i] = $urandom_range(0, 1) == 1;
          m_vld[c][i] = $urandom_range(0, 9) < 8;
        end
      for (int v = 0; v < NV; v++) begin
        s_val[v] = $urandom_range(0, 1) == 1;
        s_un[v]  = $urandom_range(0, 9) < 4;
      end
      s = $urandom_range(0, NC - 4);
      e = s + $urandom_range(0, 3);
      run(s, e, $urandom_range(0, 3) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bcp_engine.md
Name: bcp_engine

Overview:
- Boolean Constraint Propagation responder that the solver control unit drives.
- Control reads the start/end clause range for a newly assigned variable from the var start-end table and pulses start. bcp_engine then walks every clause in that range, reading clause literals from clause memory and current assignments from var state.
- For each unit clause, it pushes the implied literal onto the imply stack. On a falsified clause, it reports conflict with the offending clause index.
- It produces bcp_busy, conflict and bcp_clause_idx, and it accepts reset_bcp from control.

Parameters:
- LITS_PER_CLAUSE, 3: literal slots per clause word.
- LIT_IDX_BITS, 2: width of the literal slot counter; must satisfy 2^LIT_IDX_BITS > LITS_PER_CLAUSE.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- reset_bcp  in  1  synchronous abort/clear from control.
- start_clause  in  `MAX_CLAUSES_BITS  first clause, inclusive.
- end_clause  in  `MAX_CLAUSES_BITS  last bound, exclusive.
- clause_rd  out  1  clause memory read strobe.
- clause_addr  out  `MAX_CLAUSES_BITS  clause memory address.
- clause_lit_var  in  LITS_PER_CLAUSE*`MAX_VARS_BITS  literal variables; valid 1 cycle after clause_rd.
- clause_lit_neg  in  LITS_PER_CLAUSE  literal negation bits.
- clause_lit_valid  in  LITS_PER_CLAUSE  slot-used bits.
- vs_rd  out  1  var state read strobe.
- vs_rd_var  out  `MAX_VARS_BITS  variable queried.
- vs_val  in  1  assigned value; valid 1 cycle after vs_rd.
- vs_unassigned  in  1  1 = variable unassigned; valid 1 cycle after vs_rd.
- push_imply  out  1  imply stack push.
- var_in_imply  out  `MAX_VARS_BITS  implied variable.
- val_in_imply  out  1  implied value.
- full_imply  in  1  imply stack full.
- bcp_busy  out  1  engine active.
- conflict  out  1  falsified clause found.
- overflow  out  1  implication dropped because the imply stack was full.
- bcp_clause_idx  out  `MAX_CLAUSES_BITS  current clause; the conflicting clause once conflict=1.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; every output 0.
- reset_bcp=1 (sync): next state IDLE; bcp_busy, conflict, overflow, push_imply, clause_rd and vs_rd all 0; bcp_clause_idx=0.
  - reset_bcp has priority over start and over any in-flight operation.
- Literal evaluation:
  - true if !vs_unassigned && (vs_val != neg).
  - false if !vs_unassigned && (vs_val == neg).
  - otherwise unassigned.
- State machine:
  - IDLE: on start, latch the range, set idx=start_clause, clear conflict/overflow, set bcp_busy=1 next cycle. Go to FETCH, or to DONE if start_clause >= end_clause.
  - FETCH: clause_rd=1, clause_addr=idx, bcp_clause_idx=idx.
  - LATCH: capture the literal vectors; lit=0; unassigned_cnt=0.
  - LIT_REQ: skip slots with valid=0. If no valid slot remains, go to CLASSIFY. Else vs_rd=1, vs_rd_var=slot var.
  - LIT_EVAL:
    - literal true: clause satisfied; early-out to NEXT.
    - literal unassigned: unassigned_cnt++ (saturates at 2); remember var and polarity.
    - then lit++ and return to LIT_REQ.
  - CLASSIFY:
    - cnt=0: CONFLICT.
    - cnt=1: PUSH.
    - cnt>=2: NEXT.
  - PUSH:
    - if !full_imply: push_imply=1 for exactly 1 cycle, var_in_imply=remembered var, val_in_imply=!neg.
    - else overflow=1, no push.
    - then NEXT.
  - NEXT: idx++. If idx==end_clause go to DONE, else FETCH.
  - CONFLICT: conflict=1 and bcp_clause_idx frozen; go to DONE.
  - DONE: bcp_busy=0; conflict, overflow and bcp_clause_idx hold until the next accepted start or reset_bcp; return to IDLE.
- Cycle cost per clause: FETCH + LATCH + 2 per evaluated literal + CLASSIFY + PUSH (if unit) + NEXT.
- start while not IDLE is ignored.
- A clause with all slots invalid is treated as empty, which gives a conflict.
- Duplicate or contradictory implications are pushed as-is; control resolves them on pop.
- Index arithmetic is unsigned and modulo `MAX_CLAUSES_BITS. The end_clause == 2^`MAX_CLAUSES_BITS case is not representable; control never issues it.

Optional Feature:
- BCP_STATS_EN defined: adds outputs stat_clauses (16 bits, clauses fully visited) and stat_implies (16 bits, successful pushes).
  - Both cleared by reset_n, reset_bcp and an accepted start.
  - Both saturate at 0xFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Unit clause: range [0,1); clause 0 = (x1, ¬x2, x3); x1=0, x2=1, x3 unassigned → exactly one push with var 3, val 1; conflict=0; bcp_busy falls after 11 cycles.
- Conflict: range [4,6); clause 4 = (x1, x2), both assigned 0 → conflict=1, bcp_clause_idx=4, no push, clause 5 never read (no clause_rd with addr 5).
- Early satisfied: clause 0 = (x5, x6, x7), x5=1 → only one vs_rd issued for that clause; no push; conflict=0.
- Empty range: start_clause=7, end_clause=7 → no clause_rd, bcp_busy high 1 cycle, conflict=0.
- Abort: reset_bcp asserted during LIT_EVAL of range [0,10) → next cycle bcp_busy=0, conflict=0, no further clause_rd; a new start with [2,3) then runs normally.
- Full stack: full_imply=1 with the unit clause from the first scenario → push_imply stays 0, overflow=1, conflict=0; the next start clears overflow.
